riscv_fetch_pcgen: RTL and testbench

RISCV_FETCH_PCGEN -- requirements
Module: riscv_fetch_pcgen

---
 rtl/riscv_fetch_pcgen.sv | 161 ++++++++++++++++
 tb/tb_riscv_fetch_pcgen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_pcgen.sv
// Instruction fetch PC generator: issues one word request at a time, presents the
// returned instruction to decode, and handles redirects from the jump decoder.
module riscv_fetch_pcgen #(
    parameter logic [31:0] P_RESET_PC = 32'h0000_0000
) (
    input  logic        iclk,
    input  logic        irst_n,
    input  logic        ipc_src,
    input  logic [31:0] ipc_target,
    output logic        oimem_req,
    output logic [31:0] oimem_addr,
    input  logic        iimem_gnt,
    input  logic        iimem_rvalid,
    input  logic [31:0] iimem_rdata,
    output logic        ovalid,
    input  logic        iready,
    output logic [31:0] oinstr,
    output logic [31:0] opc,
    output logic [31:0] opc_plus4,
    output logic        oflush,
    output logic        omisaligned
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        RESP  = 3'd2,
        HOLD  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {P_RESET_PC[31:2], 2'b00};

    state_t      state_r, state_s;
    logic [31:0] fetch_pc_r, fetch_pc_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] opc_r, opc_s;
    logic [31:0] opc_plus4_r, opc_plus4_s;
    logic        valid_r, valid_s;
    logic        req_r;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_inc_s;

    // IDLE only lasts the first cycle after reset and does not honour redirects
    assign redirect_s = ipc_src & (state_r != IDLE);
    assign target_s   = {ipc_target[31:2], 2'b00};
    assign pc_inc_s   = fetch_pc_r + 32'd4;

    // Next-state and next-datapath computation
    always_comb begin
        state_s     = state_r;
        fetch_pc_s  = fetch_pc_r;
        instr_s     = instr_r;
        opc_s       = opc_r;
        opc_plus4_s = opc_plus4_r;
        valid_s     = valid_r;
        case (state_r)
            IDLE: begin
                state_s    = REQ;
                fetch_pc_s = RESET_PC_ALIGNED;
            end
            REQ: begin
                if (redirect_s) begin
                    fetch_pc_s = target_s;
                    if (iimem_gnt) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = REQ;
                    end
                end else if (iimem_gnt) begin
                    state_s = RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (redirect_s) begin
                    fetch_pc_s = target_s;
                    if (iimem_rvalid) begin
                        state_s = REQ;
                    end else begin
                        state_s = DRAIN;
                    end
                end else if (iimem_rvalid) begin
                    instr_s     = iimem_rdata;
                    opc_s       = fetch_pc_r;
                    opc_plus4_s = pc_inc_s;
                    valid_s     = 1'b1;
                    fetch_pc_s  = pc_inc_s;
                    state_s     = HOLD;
                end else begin
                    state_s = RESP;
                end
            end
            HOLD: begin
                if (redirect_s) begin
                    fetch_pc_s = target_s;
                    valid_s    = 1'b0;
                    state_s    = REQ;
                end else if (iready) begin
                    valid_s = 1'b0;
                    state_s = REQ;
                end else begin
                    state_s = HOLD;
                end
            end
            DRAIN: begin
                // A redirect coinciding with the drained beat leaves nothing outstanding
                if (redirect_s) begin
                    fetch_pc_s = target_s;
                    if (iimem_rvalid) begin
                        state_s = REQ;
                    end else begin
                        state_s = DRAIN;
                    end
                end else if (iimem_rvalid) begin
                    state_s = REQ;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s    = IDLE;
                fetch_pc_s = RESET_PC_ALIGNED;
                valid_s    = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC_ALIGNED;
            instr_r     <= 32'd0;
            opc_r       <= 32'd0;
            opc_plus4_r <= 32'd4;
            valid_r     <= 1'b0;
            req_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            fetch_pc_r  <= fetch_pc_s;
            instr_r     <= instr_s;
            opc_r       <= opc_s;
            opc_plus4_r <= opc_plus4_s;
            valid_r     <= valid_s;
            req_r       <= (state_s == REQ);
        end
    end

    assign oimem_req   = req_r;
    assign oimem_addr  = fetch_pc_r;
    assign ovalid      = valid_r;
    assign oinstr      = instr_r;
    assign opc         = opc_r;
    assign opc_plus4   = opc_plus4_r;
    assign oflush      = redirect_s;
    assign omisaligned = redirect_s & (ipc_target[1:0] != 2'b00);

endmodule

// File: tb/tb_riscv_fetch_pcgen.sv
// Bench for riscv_fetch_pcgen: directed scenarios followed by random traffic, all
// checked against a stream-level model of which instruction address comes next.
module tb_riscv_fetch_pcgen;

    logic        iclk = 1'b0;
    logic        irst_n = 1'b0;
    logic        ipc_src = 1'b0;
    logic [31:0] ipc_target = 32'd0;
    logic        iimem_gnt = 1'b0;
    logic        iimem_rvalid = 1'b0;
    logic [31:0] iimem_rdata = 32'd0;
    logic        iready = 1'b0;
    logic        oimem_req, ovalid, oflush, omisaligned;
    logic [31:0] oimem_addr, oinstr, opc, opc_plus4;
    logic        d1_req, d1_valid, d1_flush, d1_mis;
    logic [31:0] d1_addr, d1_instr, d1_opc, d1_plus4;

    int vectors = 0;
    int miscompares = 0;

    // stimulus knobs
    logic        rst_v = 1'b0, gnt_v = 1'b0, rdy_v = 1'b0, src_v = 1'b0, spur_v = 1'b0;
    logic [31:0] tgt_v = 32'd0;
    int          lat_v = 0;
    // memory responder and reference model
    logic        pending = 1'b0;
    logic [31:0] paddr = 32'd0;
    int          cnt = 0;
    logic [31:0] exp_pc = 32'd0;
    logic        prev_hold = 1'b0, prev_xfer = 1'b0, was_rst = 1'b1;
    logic [31:0] prev_instr = 32'd0, prev_opc = 32'd0;
    int          xfers = 0;

    riscv_fetch_pcgen dut (
        .iclk(iclk), .irst_n(irst_n), .ipc_src(ipc_src), .ipc_target(ipc_target),
        .oimem_req(oimem_req), .oimem_addr(oimem_addr), .iimem_gnt(iimem_gnt),
        .iimem_rvalid(iimem_rvalid), .iimem_rdata(iimem_rdata), .ovalid(ovalid),
        .iready(iready), .oinstr(oinstr), .opc(opc), .opc_plus4(opc_plus4),
        .oflush(oflush), .omisaligned(omisaligned)
    );

    riscv_fetch_pcgen #(.P_RESET_PC(32'hFFFF_FFFC)) dut_hi (
        .iclk(iclk), .irst_n(irst_n), .ipc_src(ipc_src), .ipc_target(ipc_target),
        .oimem_req(d1_req), .oimem_addr(d1_addr), .iimem_gnt(iimem_gnt),
        .iimem_rvalid(iimem_rvalid), .iimem_rdata(iimem_rdata), .ovalid(d1_valid),
        .iready(iready), .oinstr(d1_instr), .opc(d1_opc), .opc_plus4(d1_plus4),
        .oflush(d1_flush), .omisaligned(d1_mis)
    );

    initial forever #5 iclk = ~iclk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_F00D;
    endfunction

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs (called just after a falling edge), check, update model.
    task automatic apply();
        logic active, exp_flush, xfer, grant;
        irst_n     = rst_v;
        iimem_gnt  = gnt_v;
        iready     = rdy_v;
        ipc_src    = src_v;
        ipc_target = tgt_v;
        if (pending && cnt == 0) begin
            iimem_rvalid = 1'b1;
            iimem_rdata  = mem_word(paddr);
        end else if (!pending && spur_v) begin
            iimem_rvalid = 1'b1;
            iimem_rdata  = $urandom;
        end else begin
            iimem_rvalid = 1'b0;
            iimem_rdata  = $urandom;
        end
        #1;
        active    = irst_n && !was_rst;
        exp_flush = src_v && active;
        chk1("oflush", oflush, exp_flush);
        chk1("omisaligned", omisaligned, exp_flush && (tgt_v[1:0] != 2'b00));
        chk32("addr_align", {30'd0, oimem_addr[1:0]}, 32'd0);
        if (pending || ovalid) chk1("req_while_busy", oimem_req, 1'b0);
        if (!irst_n) begin
            chk1("rst_valid", ovalid, 1'b0);
            chk1("rst_req", oimem_req, 1'b0);
            chk32("rst_addr", oimem_addr, 32'h0);
        end
        if (irst_n && prev_hold) begin
            chk1("hold_valid", ovalid, 1'b1);
            chk32("hold_instr", oinstr, prev_instr);
            chk32("hold_opc", opc, prev_opc);
        end
        if (irst_n && prev_xfer) chk1("req_after_xfer", oimem_req, 1'b1);
        if (ovalid) begin
            chk32("opc_plus4", opc_plus4, opc + 32'd4);
            chk32("instr_data", oinstr, mem_word(opc));
        end
        xfer  = irst_n && ovalid && iready && !src_v;
        grant = irst_n && oimem_req && gnt_v && !src_v;
        if (xfer) begin
            chk32("xfer_pc", opc, exp_pc);
            xfers++;
        end
        if (grant) chk32("fetch_addr", oimem_addr, exp_pc);
        if (!irst_n) exp_pc = 32'h0;
        else if (exp_flush) exp_pc = {tgt_v[31:2], 2'b00};
        else if (xfer) exp_pc = exp_pc + 32'd4;
        prev_hold  = irst_n && ovalid && !iready && !src_v;
        prev_instr = oinstr;
        prev_opc   = opc;
        prev_xfer  = xfer;
        if (iimem_rvalid && pending) pending = 1'b0;
        else if (pending && cnt > 0) cnt--;
        if (irst_n && oimem_req && gnt_v) begin
            pending = 1'b1;
            paddr   = oimem_addr;
            cnt     = lat_v;
        end
        was_rst = !irst_n;
    endtask

    task automatic tick();
        @(negedge iclk);
        apply();
    endtask

    // Both waits return at a falling edge with the next cycle's inputs not yet applied.
    task automatic wait_req(input logic [31:0] exp, input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge iclk);
            if (oimem_req === 1'b1) break;
            apply();
        end
        chk1({tag, "_req"}, oimem_req, 1'b1);
        chk32(tag, oimem_addr, exp);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 30; i++) begin
            @(negedge iclk);
            if (ovalid === 1'b1) break;
            apply();
        end
        chk1(tag, ovalid, 1'b1);
    endtask

    initial begin
        logic [31:0] saved;
        int          rand_start;
        gnt_v = 1'b1; rdy_v = 1'b1; lat_v = 0;
        repeat (2) tick();
        chk32("rst_opc", opc, 32'h0);
        chk32("rst_plus4", opc_plus4, 32'h4);
        chk32("rst_instr", oinstr, 32'h0);
        chk32("rst_addr_hi", d1_addr, 32'hFFFF_FFFC);
        chk32("rst_plus4_hi", d1_plus4, 32'h4);

        // in-order fetch with immediate grant and single-cycle response
        rst_v = 1'b1;
        wait_req(32'h0, "addr0");
        chk32("addr0_hi", d1_addr, 32'hFFFF_FFFC);
        apply();
        wait_valid("valid0");
        chk32("opc0", opc, 32'h0);
        chk32("plus4_0", opc_plus4, 32'h4);
        chk32("opc0_hi", d1_opc, 32'hFFFF_FFFC);
        chk32("plus4_0_hi", d1_plus4, 32'h0);
        apply();
        wait_req(32'h4, "addr4");
        chk1("valid_one_cycle", ovalid, 1'b0);
        chk32("addr_wrap_hi", d1_addr, 32'h0);
        rdy_v = 1'b0;
        apply();

        // decode stalls for five cycles
        wait_valid("valid4");
        chk32("opc4", opc, 32'h4);
        saved = oinstr;
        apply();
        repeat (5) begin
            tick();
            chk1("stall_valid", ovalid, 1'b1);
            chk32("stall_opc", opc, 32'h4);
            chk32("stall_instr", oinstr, saved);
            chk1("stall_noreq", oimem_req, 1'b0);
        end
        rdy_v = 1'b1;
        tick();

        // redirect in the grant cycle of 0x8
        wait_req(32'h8, "addr8");
        src_v = 1'b1; tgt_v = 32'h100;
        apply();
        chk1("flush_grant", oflush, 1'b1);
        chk1("mis_grant", omisaligned, 1'b0);
        src_v = 1'b0;
        wait_req(32'h100, "addr100");
        gnt_v = 1'b0;
        apply();

        // misaligned redirect while ungranted
        src_v = 1'b1; tgt_v = 32'h203;
        tick();
        chk1("flush_mis", oflush, 1'b1);
        chk1("mis_pulse", omisaligned, 1'b1);
        src_v = 1'b0; gnt_v = 1'b1;
        wait_req(32'h200, "addr200");
        lat_v = 5;
        apply();

        // reset while a response is outstanding, beat arrives after release
        tick();
        rst_v = 1'b0;
        tick();
        chk32("midrst_opc", opc, 32'h0);
        chk32("midrst_plus4", opc_plus4, 32'h4);
        chk32("midrst_instr", oinstr, 32'h0);
        tick();
        rst_v = 1'b1; cnt = 0; lat_v = 1;
        tick();
        chk1("late_beat_ignored", ovalid, 1'b0);
        wait_req(32'h0, "addr_after_rst");
        chk1("no_valid_after_rst", ovalid, 1'b0);
        apply();
        wait_valid("valid_after_rst");
        chk32("opc_after_rst", opc, 32'h0);
        apply();

        // random traffic
        rand_start = xfers;
        for (int i = 0; i < 3000; i++) begin
            @(negedge iclk);
            gnt_v  = ($urandom_range(0, 99) < 60);
            rdy_v  = ($urandom_range(0, 99) < 65);
            src_v  = ($urandom_range(0, 99) < 4);
            spur_v = ($urandom_range(0, 99) < 5);
            tgt_v  = $urandom;
            if ($urandom_range(0, 1) == 0) tgt_v[1:0] = 2'b00;
            lat_v  = $urandom_range(0, 3);
            apply();
        end
        chk1("progress", (xfers - rand_start) > 50, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
